// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared constants for the serial FP32 adder host interface:
//   - FSM state encodings (IDLE .. HOLD)
//   - FP32_QNAN, the word returned when a computation is aborted
//   - cnt_width(), width of a bit counter able to index a WIDTH-bit word
// -----------------------------------------------------------------------------
package fp32_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT_A = 3'd1;
    localparam logic [2:0] SHIFT_B = 3'd2;
    localparam logic [2:0] START   = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] SHIFT_C = 3'd5;
    localparam logic [2:0] HOLD    = 3'd6;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // One spare bit above clog2 so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fp32_bitcnt.sv
// -----------------------------------------------------------------------------
// fp32_bitcnt
// Clearable up-counter shared by the three serial phases (A, B, result).
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   clr    - synchronous clear to 0 (has priority over en)
//   en     - count enable
//   tc     - terminal count: high while the count equals WIDTH-1
// -----------------------------------------------------------------------------
module fp32_bitcnt
    import fp32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/fp32_serial_io.sv
// -----------------------------------------------------------------------------
// fp32_serial_io
// Host front/back end of the serial FP32 adder. Takes an operand pair over a
// valid/ready handshake, shifts A then B MSB-first onto inpab with lda/ldb
// strobes, pulses start, waits for done, shifts the result in from out_c while
// driving shc, and presents the word on res with a res_valid/res_ready
// handshake.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   in_valid/in_ready      - operand handshake; in_a, in_b operands
//   inpab, lda, ldb        - serial operand bit and A/B shift enables
//   start, done            - controller start pulse and completion pulse
//   shc, out_c             - result register shift enable and serial bit
//   res_valid/res_ready    - result handshake; res result word
//   busy                   - high in every state except IDLE
//   err                    - watchdog abort flag
// Optional build macro FP_IO_TIMEOUT_EN: enables a watchdog in WAIT that
// aborts after TIMEOUT cycles without done, returning FP32_QNAN with err=1.
// Without it err is tied low and WAIT waits indefinitely.
// All outputs are flops; each is loaded with the value matching the state
// being entered, so nothing reaches an output combinationally.
// -----------------------------------------------------------------------------
module fp32_serial_io
    import fp32_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             inpab,
    output logic             lda,
    output logic             ldb,
    output logic             start,
    input  logic             done,
    output logic             shc,
    input  logic             out_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             err
);

    logic [2:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;

    logic accept;
    logic done_take;
    logic cnt_en;
    logic cnt_clr;
    logic cnt_tc;

    assign accept    = (state == IDLE) && in_valid;
    assign done_take = (state == WAIT) && done;
    assign cnt_en    = (state == SHIFT_A) || (state == SHIFT_B) || (state == SHIFT_C);
    assign cnt_clr   = accept || done_take || (cnt_en && cnt_tc);

    fp32_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

`ifdef FP_IO_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd;
    logic           timeout_hit;
    logic           err_flag;

    // Counts cycles spent in WAIT; held at zero everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (state != WAIT) begin
            wd <= '0;
        end else begin
            wd <= wd + WDW'(1);
        end
    end

    assign timeout_hit = (state == WAIT) && (wd == WDW'(TIMEOUT - 1));
    assign err         = err_flag;
`else
    localparam int timeout_unused = TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            inpab     <= 1'b0;
            lda       <= 1'b0;
            ldb       <= 1'b0;
            start     <= 1'b0;
            shc       <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
            res_sr    <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
`ifdef FP_IO_TIMEOUT_EN
            err_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // The MSB goes straight to inpab; the latches keep the
                        // remaining bits left-justified for the following cycles.
                        a_sr     <= {in_a[WIDTH-2:0], 1'b0};
                        b_sr     <= in_b;
                        inpab    <= in_a[WIDTH-1];
                        lda      <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT_A;
                    end
                end
                SHIFT_A: begin
                    if (cnt_tc) begin
                        inpab <= b_sr[WIDTH-1];
                        b_sr  <= {b_sr[WIDTH-2:0], 1'b0};
                        lda   <= 1'b0;
                        ldb   <= 1'b1;
                        state <= SHIFT_B;
                    end else begin
                        inpab <= a_sr[WIDTH-1];
                        a_sr  <= {a_sr[WIDTH-2:0], 1'b0};
                    end
                end
                SHIFT_B: begin
                    if (cnt_tc) begin
                        inpab <= 1'b0;
                        ldb   <= 1'b0;
                        start <= 1'b1;
                        state <= START;
                    end else begin
                        inpab <= b_sr[WIDTH-1];
                        b_sr  <= {b_sr[WIDTH-2:0], 1'b0};
                    end
                end
                START: begin
                    // done is not examined here, so a done coincident with
                    // start is dropped.
                    start <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        shc   <= 1'b1;
                        state <= SHIFT_C;
                    end
`ifdef FP_IO_TIMEOUT_EN
                    else if (timeout_hit) begin
                        res       <= WIDTH'(FP32_QNAN);
                        res_valid <= 1'b1;
                        err_flag  <= 1'b1;
                        state     <= HOLD;
                    end
`endif
                end
                SHIFT_C: begin
                    // out_c is the result register MSB, so the first sample
                    // ends up at bit WIDTH-1 after WIDTH left shifts.
                    res_sr <= {res_sr[WIDTH-2:0], out_c};
                    if (cnt_tc) begin
                        res       <= {res_sr[WIDTH-2:0], out_c};
                        shc       <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef FP_IO_TIMEOUT_EN
                        err_flag  <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    inpab     <= 1'b0;
                    lda       <= 1'b0;
                    ldb       <= 1'b0;
                    start     <= 1'b0;
                    shc       <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_serial_io.sv
// -----------------------------------------------------------------------------
// tb_fp32_serial_io
// Directed bench for fp32_serial_io. A stub controller loads a result word on
// done and shifts it out MSB-first on out_c whenever shc is high; a monitor
// rebuilds the A/B words from inpab on lda/ldb cycles.
// -----------------------------------------------------------------------------
module tb_fp32_serial_io;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          inpab;
    logic          lda;
    logic          ldb;
    logic          start;
    logic          done = 1'b0;
    logic          shc;
    logic          out_c;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    fp32_serial_io #(
        .WIDTH   (W),
        .TIMEOUT (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .inpab     (inpab),
        .lda       (lda),
        .ldb       (ldb),
        .start     (start),
        .done      (done),
        .shc       (shc),
        .out_c     (out_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .busy      (busy),
        .err       (err)
    );

    // Edge counter: at a negedge it equals the index of the preceding posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;
    logic [W-1:0] rr = '0;
    logic [W-1:0] stub_val = '0;
    int           n_lda = 0;
    int           n_ldb = 0;
    int           stray = 0;

    always @(posedge clk) begin
        if (lda) begin
            cap_a <= {cap_a[W-2:0], inpab};
            n_lda <= n_lda + 1;
        end
        if (ldb) begin
            cap_b <= {cap_b[W-2:0], inpab};
            n_ldb <= n_ldb + 1;
        end
        if (done) rr <= stub_val;
        else if (shc) rr <= {rr[W-2:0], 1'b0};
    end

    always @(negedge clk) begin
        if (reset && !lda && !ldb && inpab) stray <= stray + 1;
    end

    assign out_c = rr[W-1];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    bit pending_b2b = 1'b0;
    int last_h = 0;

    // One full transaction. Call right after a negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                          input int dly, input int hold, input bit spur, input bit b2b,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        int  e_edge;
        int  d_edge;
        int  k;
        int  n0a;
        int  n0b;
        bit  got;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (in_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) check("accept_seen", 0, 1);
        e_edge = cyc + 1;
        if (pending_b2b) check("b2b_gap", e_edge - last_h, 1);
        pending_b2b = 1'b0;
        n0a      = n_lda;
        n0b      = n_ldb;
        stub_val = r;
        @(posedge clk);
        #1 in_valid = 1'b0;

        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            done = 1'b0;
            k = cyc - e_edge + 1;
            if (k == 1) check("lda_first", {31'd0, lda}, 1);
            if (spur && k == 40) done = 1'b1;
            if (start) begin
                got = 1'b1;
                check("start_lat", k, 65);
                if (spur) done = 1'b1;
            end
        end
        if (!got) check("start_seen", 0, 1);
        check("cap_a", cap_a, a);
        check("cap_b", cap_b, b);
        check("n_lda", n_lda - n0a, 32);
        check("n_ldb", n_ldb - n0b, 32);

        @(negedge clk);
        done = 1'b0;
        check("start_pulse", {31'd0, start}, 0);
        repeat (dly) @(negedge clk);
        check("wait_state", {29'd0, shc, res_valid, busy}, 32'd1);
        done = 1'b1;
        @(negedge clk);
        done   = 1'b0;
        d_edge = cyc;
        check("shc_first", {31'd0, shc}, 1);

        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (res_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) check("res_valid_seen", 0, 1);
        check("res_lat", cyc - d_edge + 1, 33);
        check("res", res, r);
        check("err_clear", {31'd0, err}, 0);

        if (hold > 0) begin
            in_valid = 1'b1;
            in_a     = ~a;
            for (int i = 0; i < hold; i++) begin
                check("hold_flags", {29'd0, res_valid, in_ready, busy}, 32'd5);
                check("hold_res", res, r);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end

        res_ready = 1'b1;
        if (b2b) begin
            in_a        = na;
            in_b        = nb;
            in_valid    = 1'b1;
            pending_b2b = 1'b1;
            last_h      = cyc + 1;
        end
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("post_hs", {29'd0, in_ready, res_valid, busy}, 32'd4);
        check("res_keep", res, r);
        $display("op a=%h b=%h res=%h", a, b, res);
    endtask

    initial begin
        #12;
        check("rst_flags", {23'd0, in_ready, inpab, lda, ldb, start, shc, res_valid, busy, err},
              32'h100);
        check("rst_res", res, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // basic add 1.0 + 2.0
        run_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 10, 0, 1'b0, 1'b0, '0, '0);
        // result held for 5 cycles with res_ready low
        run_op(32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 4, 5, 1'b0, 1'b0, '0, '0);
        // spurious done in SHIFT_B and in the start cycle
        run_op(32'h4120_0000, 32'hC000_0000, 32'h4100_0000, 6, 0, 1'b1, 1'b0, '0, '0);

        // reset at count 12 of SHIFT_A
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h1234_5678;
        in_valid = 1'b1;
        check("rst_test_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (13) @(negedge clk);
        check("rst_test_lda", {31'd0, lda}, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_flags", {23'd0, in_ready, inpab, lda, ldb, start, shc, res_valid, busy, err},
              32'h100);
        check("midrst_res", res, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 3, 0, 1'b0, 1'b0, '0, '0);

        // back-to-back operations
        run_op(32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, 2, 0, 1'b0, 1'b1,
               32'h3F00_0000, 32'h3F00_0000);
        run_op(32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 2, 0, 1'b0, 1'b0, '0, '0);

`ifdef FP_IO_TIMEOUT_EN
        begin : timeout_test
            int  e_edge;
            int  ks;
            bit  got;
            in_a     = 32'h4000_0000;
            in_b     = 32'h4000_0000;
            in_valid = 1'b1;
            e_edge   = cyc + 1;
            check("to_ready", {31'd0, in_ready}, 1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            ks  = 0;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (start) begin
                    got = 1'b1;
                    ks  = cyc - e_edge + 1;
                end
            end
            if (!got) check("to_start_seen", 0, 1);
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (res_valid) got = 1'b1;
            end
            if (!got) check("to_valid_seen", 0, 1);
            check("to_lat", (cyc - e_edge + 1) - ks, 21);
            check("to_res", res, 32'h7FC0_0000);
            check("to_err", {31'd0, err}, 1);
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            check("to_err_clr", {30'd0, err, in_ready}, 32'd1);
            $display("op timeout res=%h", res);
        end
`endif

        check("stray_inpab", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
